// File: rtl/dbg_apb_mgr_nport.sv
// APB manager for the JTAG debug path: one debug request becomes one APB transfer
// on one of NPORT targets, with stride auto-increment, wait timeout and port-range check.
module dbg_apb_mgr_nport #(
  parameter int NPORT   = 2,
  parameter int AW      = 32,
  parameter int DW      = 48,
  parameter int TIMEOUT = 255,
  parameter int PW      = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic                req_incr_i,
  input  logic [3:0]          req_stride_i,
  input  logic [PW-1:0]       req_port_i,
  input  logic [AW-1:0]       req_addr_i,
  input  logic [DW-1:0]       req_wdata_i,
  output logic                rsp_valid_o,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                busy_o,
  output logic [NPORT-1:0]    psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [AW-1:0]       paddr_o,
  output logic [DW-1:0]       pwdata_o,
  input  logic [NPORT*DW-1:0] prdata_i,
  input  logic [NPORT-1:0]    pready_i,
  input  logic [NPORT-1:0]    pslverr_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t         r_state, w_state_nxt;
  logic [PW-1:0]  r_port;
  logic [AW-1:0]  r_addr;
  logic [CW-1:0]  r_wcnt;
  logic [AW-1:0]  r_paddr;
  logic           r_pwrite;
  logic [DW-1:0]  r_pwdata;
  logic           r_rsp_valid, r_rsp_err, r_rsp_to;
  logic [DW-1:0]  r_rdata;

  logic           w_accept, w_port_ok, w_done, w_tout;
  logic [PW-1:0]  w_port_res;
  logic [AW-1:0]  w_addr_res;
  logic [NPORT-1:0] w_psel;
  logic [DW-1:0]  w_sel_rdata;
  logic           w_sel_ready, w_sel_err;

  assign w_accept   = req_valid_i & req_ready_o;
  assign w_port_res = req_incr_i ? r_port : req_port_i;
  assign w_addr_res = req_incr_i ? (r_addr + AW'(req_stride_i)) : req_addr_i;
  assign w_port_ok  = int'(w_port_res) < NPORT;

  // Explicit decode keeps an out-of-range stored index from ever selecting a slice.
  always_comb begin
    w_psel      = '0;
    w_sel_rdata = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      if (r_port == PW'(k)) begin
        w_psel[k]   = 1'b1;
        w_sel_rdata = prdata_i[k*DW +: DW];
        w_sel_ready = pready_i[k];
        w_sel_err   = pslverr_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    psel_o      = w_psel;
    penable_o   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = ~rst_i;
        busy_o      = 1'b0;
        psel_o      = '0;
        if (w_accept && w_port_ok) w_state_nxt = S_SETUP;
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        penable_o = 1'b1;
        if (w_sel_ready) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end else if (TIMEOUT != 0 && r_wcnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_tout      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        psel_o      = '0;
      end
    endcase
  end

  // Bus-side copies load only when a real transfer starts, so they hold through IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_port      <= '0;
      r_addr      <= '0;
      r_wcnt      <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_wcnt      <= (r_state == S_ACCESS && w_state_nxt == S_ACCESS) ? r_wcnt + 1'b1 : '0;
      if (w_accept) begin
        r_port <= w_port_res;
        r_addr <= w_addr_res;
        if (w_port_ok) begin
          r_paddr  <= w_addr_res;
          r_pwrite <= req_write_i;
          r_pwdata <= req_wdata_i;
        end else begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
          r_rsp_to    <= 1'b0;
        end
      end
      if (w_done) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_sel_err;
        r_rsp_to    <= 1'b0;
        if (!r_pwrite) r_rdata <= w_sel_rdata;
      end
      if (w_tout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_rsp_to    <= 1'b1;
      end
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rdata;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_to;
  assign paddr_o       = r_paddr;
  assign pwrite_o      = r_pwrite;
  assign pwdata_o      = r_pwdata;

endmodule

// File: tb/tb_dbg_apb_mgr_nport.sv
// Directed bench for dbg_apb_mgr_nport: 3 ports, 48-bit data, 16-cycle timeout.
module tb_dbg_apb_mgr_nport;
  localparam int NPORT = 3;
  localparam int AW    = 32;
  localparam int DW    = 48;
  localparam int TO    = 16;
  localparam int PW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                req_valid, req_ready, req_write, req_incr;
  logic [3:0]          req_stride;
  logic [PW-1:0]       req_port;
  logic [AW-1:0]       req_addr;
  logic [DW-1:0]       req_wdata;
  logic                rsp_valid, rsp_err, rsp_timeout, busy;
  logic [DW-1:0]       rsp_rdata;
  logic [NPORT-1:0]    psel;
  logic                penable, pwrite;
  logic [AW-1:0]       paddr;
  logic [DW-1:0]       pwdata;
  logic [NPORT*DW-1:0] prdata;
  logic [NPORT-1:0]    pready, pslverr;

  int total = 0;
  int bad   = 0;

  dbg_apb_mgr_nport #(.NPORT(NPORT), .AW(AW), .DW(DW), .TIMEOUT(TO), .PW(PW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_incr_i(req_incr), .req_stride_i(req_stride), .req_port_i(req_port),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy),
    .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge inside SETUP.
  task automatic drive(input logic w, input logic inc, input logic [3:0] stride,
                       input logic [PW-1:0] port, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_incr = inc; req_stride = stride;
    req_port = port; req_addr = addr; req_wdata = wd;
    chk("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Zero-wait transfer from the SETUP negedge through the completion negedge.
  task automatic beat(input string tag, input logic [NPORT-1:0] sel,
                      input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd);
    chk({tag, ":setup_psel"}, psel, sel);
    chk({tag, ":setup_pen"}, penable, 1'b0);
    chk({tag, ":paddr"}, paddr, addr);
    chk({tag, ":pwrite"}, pwrite, wr);
    if (wr) chk({tag, ":pwdata"}, pwdata, wd);
    @(negedge clk);
    chk({tag, ":acc_psel"}, psel, sel);
    chk({tag, ":acc_pen"}, penable, 1'b1);
    chk({tag, ":acc_rspv"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({tag, ":rspv"}, rsp_valid, 1'b1);
    chk({tag, ":done_psel"}, psel, '0);
    chk({tag, ":busy"}, busy, 1'b0);
    chk({tag, ":tout"}, rsp_timeout, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_incr = 1'b0; req_stride = '0;
    req_port = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = '1; pslverr = '0;

    repeat (2) @(negedge clk);
    chk("rst:ready", req_ready, 1'b0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:psel", psel, '0);
    chk("rst:pen", penable, 1'b0);
    chk("rst:paddr", paddr, '0);
    chk("rst:rspv", rsp_valid, 1'b0);
    chk("rst:rdata", rsp_rdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst:ready", req_ready, 1'b1);

    // Read port 1; unselected ports flag slverr and must be ignored
    prdata[0*DW +: DW] = 48'h0000_DEAD_0000;
    prdata[1*DW +: DW] = 48'hABCD_1234_5678;
    prdata[2*DW +: DW] = 48'h5555_5555_5555;
    pslverr = 3'b101;
    drive(1'b0, 1'b0, 4'd0, 2'd1, 32'h100, '0);
    beat("rd1", 3'b010, 32'h100, 1'b0, '0);
    chk("rd1:rdata", rsp_rdata, 48'hABCD_1234_5678);
    chk("rd1:err", rsp_err, 1'b0);
    @(negedge clk);
    chk("rd1:pulse_end", rsp_valid, 1'b0);
    chk("rd1:rdata_hold", rsp_rdata, 48'hABCD_1234_5678);
    pslverr = '0;

    // Write then three stride-4 incr writes
    drive(1'b1, 1'b0, 4'd0, 2'd0, 32'h20, 48'h10);
    beat("wr0", 3'b001, 32'h20, 1'b1, 48'h10);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'd4, 2'd2, 32'hDEAD, 48'h10 + 48'(i));
      beat("wr_incr", 3'b001, 32'h20 + 32'(4 * i), 1'b1, 48'h10 + 48'(i));
    end
    chk("wr:rdata_untouched", rsp_rdata, 48'hABCD_1234_5678);

    // Address wrap
    drive(1'b1, 1'b0, 4'd0, 2'd0, 32'hFFFF_FFFC, 48'h1);
    beat("wrap_base", 3'b001, 32'hFFFF_FFFC, 1'b1, 48'h1);
    drive(1'b1, 1'b1, 4'd8, 2'd0, 32'h0, 48'h2);
    beat("wrap", 3'b001, 32'h0000_0004, 1'b1, 48'h2);

    // Timeout on port 2: response at ACCESS entry + 16
    pready = '0;
    drive(1'b0, 1'b0, 4'd0, 2'd2, 32'h40, '0);
    chk("to:setup_psel", psel, 3'b100);
    repeat (16) @(negedge clk);
    chk("to:not_early", rsp_valid, 1'b0);
    chk("to:still_acc", penable, 1'b1);
    @(negedge clk);
    chk("to:rspv", rsp_valid, 1'b1);
    chk("to:err", rsp_err, 1'b1);
    chk("to:tout", rsp_timeout, 1'b1);
    chk("to:rdata", rsp_rdata, 48'hABCD_1234_5678);
    chk("to:psel", psel, '0);
    chk("to:pen", penable, 1'b0);
    chk("to:paddr_hold", paddr, 32'h40);

    // Out-of-range port
    pready = '1;
    drive(1'b0, 1'b0, 4'd0, 2'd3, 32'h999, '0);
    chk("oor:rspv", rsp_valid, 1'b1);
    chk("oor:err", rsp_err, 1'b1);
    chk("oor:tout", rsp_timeout, 1'b0);
    chk("oor:psel", psel, '0);
    chk("oor:busy", busy, 1'b0);
    chk("oor:paddr_hold", paddr, 32'h40);
    @(negedge clk);
    chk("oor:pulse_end", rsp_valid, 1'b0);

    // Slave error on a read still captures data
    prdata[0*DW +: DW] = 48'h1111_2222_3333;
    pslverr = 3'b001;
    drive(1'b0, 1'b0, 4'd0, 2'd0, 32'h50, '0);
    beat("slverr", 3'b001, 32'h50, 1'b0, '0);
    chk("slverr:err", rsp_err, 1'b1);
    chk("slverr:rdata", rsp_rdata, 48'h1111_2222_3333);
    pslverr = '0;

    // One wait state
    pready = '0;
    prdata[1*DW +: DW] = 48'h0102_0304_0506;
    drive(1'b0, 1'b0, 4'd0, 2'd1, 32'h60, '0);
    @(negedge clk);
    chk("ws:acc", penable, 1'b1);
    @(negedge clk);
    chk("ws:no_rsp", rsp_valid, 1'b0);
    chk("ws:busy", busy, 1'b1);
    pready = '1;
    @(negedge clk);
    chk("ws:rspv", rsp_valid, 1'b1);
    chk("ws:rdata", rsp_rdata, 48'h0102_0304_0506);
    chk("ws:err", rsp_err, 1'b0);

    // Reset during ACCESS
    pready = '0;
    drive(1'b1, 1'b0, 4'd0, 2'd1, 32'h300, 48'h77);
    @(negedge clk);
    chk("mrst:in_acc", penable, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst:psel", psel, '0);
    chk("mrst:pen", penable, 1'b0);
    chk("mrst:busy", busy, 1'b0);
    chk("mrst:rspv", rsp_valid, 1'b0);
    chk("mrst:paddr", paddr, '0);
    chk("mrst:pwrite", pwrite, 1'b0);
    chk("mrst:pwdata", pwdata, '0);
    chk("mrst:rdata", rsp_rdata, '0);
    chk("mrst:ready", req_ready, 1'b0);
    rst = 1'b0;
    pready = '1;
    @(negedge clk);
    chk("mrst:no_rsp", rsp_valid, 1'b0);
    chk("mrst:ready_back", req_ready, 1'b1);

    // Incr right after reset starts from port 0, address 0
    drive(1'b0, 1'b1, 4'd4, 2'd2, 32'hFFF, '0);
    beat("incr_rst", 3'b001, 32'h4, 1'b0, '0);
    chk("incr_rst:rdata", rsp_rdata, 48'h1111_2222_3333);

    drive(1'b0, 1'b0, 4'd0, 2'd1, 32'h8, '0);
    beat("post_rst_rd", 3'b010, 32'h8, 1'b0, '0);
    chk("post_rst_rd:rdata", rsp_rdata, 48'h0102_0304_0506);
    chk("post_rst_rd:err", rsp_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
